// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer and instruction register for the 16-bit CPU.
// Steps through HALT/FETCH/EXEC1/EXEC2. It latches the instruction RAM word
// into the IR, inserts EXEC2 when the decoder asks for it, halts on STP,
// supports run/single-step control and counts retired instructions.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   HALT  | idle; leave on run=1 (or automatically right after reset)
//   FETCH | wait out RAM read latency, capture IR on the last cycle
//   EXEC1 | first execute phase; STP halts, E2 requests EXEC2
//   EXEC2 | second execute phase, then next fetch (or HALT when stepping)
module cpu_sequencer #(
  parameter int FETCH_CYCLES = 1,
  parameter int CNT_W        = 16,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             run,
  input  logic             step_mode,
  input  logic [15:0]      instr_in,
  input  logic             E2,
  output logic [15:0]      instr,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int FC_W = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FETCH_CYCLES - 1);

  // One-hot encoding so the phase outputs come straight from state flops.
  typedef enum logic [3:0] {
    S_HALT  = 4'b1000,
    S_FETCH = 4'b0100,
    S_EXEC1 = 4'b0010,
    S_EXEC2 = 4'b0001
  } state_t;

  state_t          state, state_nxt;
  logic [FC_W-1:0] fcnt, fcnt_nxt;
  logic            start_pend;
  logic            ld_ir;
  logic            retire;
  logic            is_stp;

  assign is_stp = ~instr[15] & (instr[14:9] == 6'h3F);
  assign {halted, FETCH, EXEC1, EXEC2} = state;

  // Next-state, IR load and retire decisions.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    ld_ir     = 1'b0;
    retire    = 1'b0;
    case (state)
      S_HALT: begin
        fcnt_nxt = '0;
        if (run || start_pend) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (fcnt == FC_LAST) begin
          ld_ir     = 1'b1;
          fcnt_nxt  = '0;
          state_nxt = S_EXEC1;
        end else begin
          fcnt_nxt = fcnt + FC_W'(1);
        end
      end
      S_EXEC1: begin
        if (is_stp) begin
          retire    = 1'b1;
          state_nxt = S_HALT;
        end else if (E2) begin
          state_nxt = S_EXEC2;
        end else begin
          retire    = 1'b1;
          state_nxt = step_mode ? S_HALT : S_FETCH;
        end
      end
      S_EXEC2: begin
        retire    = 1'b1;
        state_nxt = step_mode ? S_HALT : S_FETCH;
      end
      default: begin
        fcnt_nxt  = '0;
        state_nxt = S_HALT;
      end
    endcase
  end

  // State, fetch counter, IR, retired counter and auto-start flag.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= S_HALT;
      fcnt       <= '0;
      instr      <= 16'h0000;
      retired    <= '0;
      start_pend <= AUTO_START;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      if (ld_ir)  instr   <= instr_in;
      if (retire) retired <= retired + CNT_W'(1);
      if (state == S_HALT && state_nxt != S_HALT) start_pend <= 1'b0;
    end
  end

endmodule
